// File: rtl/wb_write_ctrl_pkg.sv
// Shared definitions for the writeback-stage controller.
//   - LD_* load-type encodings carried on mem_ld_type_i
//   - default data/address widths
//   - ZeroWord constant used for register-file data reset
package wb_write_ctrl_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   localparam logic [DATA_W_DEF-1:0] ZeroWord = '0;

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_LB   = 3'd1,
      LD_LBU  = 3'd2,
      LD_LH   = 3'd3,
      LD_LHU  = 3'd4,
      LD_LW   = 3'd5
   } ld_type_e;

endpackage

// File: rtl/wb_write_ctrl_late_fifo.sv
// wb_late_fifo: circular queue holding late divider results waiting for an
// idle register-file write slot.
//   clk, rst        clock, synchronous active-low reset
//   push/push_addr/push_data  enqueue one entry (caller guarantees not full)
//   pop             dequeue the head (caller guarantees non-empty)
//   inv/inv_addr    clear the live bit of every entry whose address matches
//   head_valid      head entry is occupied and still live
//   head_addr/head_data  head entry contents
//   count           number of occupied slots (live or invalidated)
//   live            at least one live entry is queued
module wb_late_fifo #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [ADDR_W-1:0]          push_addr,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   input  logic                       inv,
   input  logic [ADDR_W-1:0]          inv_addr,
   output logic                       head_valid,
   output logic [ADDR_W-1:0]          head_addr,
   output logic [DATA_W-1:0]          head_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       live
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [DEPTH-1:0]  valid_reg;
   logic [DEPTH-1:0]  valid_next;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [CNT_W-1:0]  count_reg;

   // Live bits are cleared on pop as well, so an unoccupied slot is never
   // live and `live` is a plain OR of the vector.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_valid
         assign valid_next[gi] =
            (push && wr_ptr_reg == PTR_W'(gi))       ? 1'b1 :
            (pop  && rd_ptr_reg == PTR_W'(gi))       ? 1'b0 :
            (inv  && addr_mem[gi] == inv_addr)       ? 1'b0 :
                                                       valid_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_reg  <= '0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         valid_reg  <= valid_next;
         count_reg  <= count_reg + CNT_W'(push) - CNT_W'(pop);
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
      end
   end

   // Entry payload needs no reset: it is only observed while its live bit is set.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_reg] <= push_addr;
         data_mem[wr_ptr_reg] <= push_data;
      end
   end

   assign head_valid = valid_reg[rd_ptr_reg];
   assign head_addr  = addr_mem[rd_ptr_reg];
   assign head_data  = data_mem[rd_ptr_reg];
   assign count      = count_reg;
   assign live       = |valid_reg;

endmodule

// File: rtl/wb_write_ctrl.sv
// wb_write_ctrl: writeback-stage owner of the register-file write port.
//   clk, rst            clock, synchronous active-low reset
//   stall_i             MEM held; WB takes a bubble this edge
//   mem_*_i             MEM-stage result, load type/lane and raw read word
//   div_valid_i/wd/wdata  late divider result, accepted when div_ready_o
//   div_ready_o         late-write queue has room
//   we_o/waddr_o/wdata_o  registered register-file write port
//   stallreq_o          queued divider result starved of write slots
module wb_write_ctrl
   import wb_write_ctrl_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              mem_wreg_i,
   input  logic [ADDR_W-1:0] mem_wd_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic [2:0]        mem_ld_type_i,
   input  logic [1:0]        mem_addr_lo_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              div_valid_i,
   input  logic [ADDR_W-1:0] div_wd_i,
   input  logic [DATA_W-1:0] div_wdata_i,
   output logic              div_ready_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              stallreq_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   logic              we_reg;
   logic [ADDR_W-1:0] waddr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic              stallreq_reg;
   logic              div_ready_reg;
   logic [STV_W-1:0]  starve_cnt_reg;
   logic [STV_W-1:0]  starve_cnt_next;

   logic              slot_valid;
   logic              push_store;
   logic              drain;
   logic              silent_pop;
   logic              pop;
   logic              head_valid;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W-1:0]  count_next;
   logic              fifo_live;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DATA_W-1:0] ld_data;

   // A write to $0 is not a real write and leaves the port free for the queue.
   assign slot_valid = !stall_i && mem_wreg_i && (mem_wd_i != '0);

   // Results for $0 and results overtaken by a same-cycle pipeline write to
   // the same register are accepted by the handshake but never stored.
   assign push_store = div_valid_i && div_ready_reg && (div_wd_i != '0) &&
                       !(slot_valid && (div_wd_i == mem_wd_i));

   assign drain      = !slot_valid && head_valid;
   // Invalidated heads are retired without the port, even while the pipeline writes.
   assign silent_pop = (fifo_count != '0) && !head_valid;
   assign pop        = drain || silent_pop;
   assign count_next = fifo_count + CNT_W'(push_store) - CNT_W'(pop);

   wb_late_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push_store),
      .push_addr  (div_wd_i),
      .push_data  (div_wdata_i),
      .pop        (pop),
      .inv        (slot_valid),
      .inv_addr   (mem_wd_i),
      .head_valid (head_valid),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .count      (fifo_count),
      .live       (fifo_live)
   );

   // Big-endian lanes: addr_lo 0 is the most significant byte.
   always_comb begin
      ld_byte = mem_rdata_i[7:0];
      case (mem_addr_lo_i)
         2'd0:    ld_byte = mem_rdata_i[31:24];
         2'd1:    ld_byte = mem_rdata_i[23:16];
         2'd2:    ld_byte = mem_rdata_i[15:8];
         default: ld_byte = mem_rdata_i[7:0];
      endcase
      ld_half = mem_addr_lo_i[1] ? mem_rdata_i[15:0] : mem_rdata_i[31:16];
      ld_data = mem_wdata_i;
      case (mem_ld_type_i)
         LD_LB:   ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
         LD_LBU:  ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
         LD_LH:   ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
         LD_LHU:  ld_data = {{(DATA_W-16){1'b0}}, ld_half};
         LD_LW:   ld_data = mem_rdata_i;
         default: ld_data = mem_wdata_i;
      endcase
   end

   // Saturating count of cycles a live entry waited without draining.
   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (drain || !fifo_live) begin
         starve_cnt_next = '0;
      end else if (starve_cnt_reg != STV_W'(STARVE_LIMIT)) begin
         starve_cnt_next = starve_cnt_reg + STV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         we_reg         <= 1'b0;
         waddr_reg      <= '0;
         wdata_reg      <= ZeroWord;
         stallreq_reg   <= 1'b0;
         div_ready_reg  <= 1'b0;
         starve_cnt_reg <= '0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
         stallreq_reg   <= !drain && (starve_cnt_reg == STV_W'(STARVE_LIMIT));
         div_ready_reg  <= (count_next < CNT_W'(FIFO_DEPTH));
         if (slot_valid) begin
            we_reg    <= 1'b1;
            waddr_reg <= mem_wd_i;
            wdata_reg <= ld_data;
         end else if (drain) begin
            we_reg    <= 1'b1;
            waddr_reg <= head_addr;
            wdata_reg <= head_data;
         end else begin
            we_reg    <= 1'b0;
         end
      end
   end

   assign we_o        = we_reg;
   assign waddr_o     = waddr_reg;
   assign wdata_o     = wdata_reg;
   assign stallreq_o  = stallreq_reg;
   assign div_ready_o = div_ready_reg;

endmodule

// File: tb/tb_wb_write_ctrl.sv
module tb_wb_write_ctrl;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        mem_wreg_i;
   logic [4:0]  mem_wd_i;
   logic [31:0] mem_wdata_i;
   logic [2:0]  mem_ld_type_i;
   logic [1:0]  mem_addr_lo_i;
   logic [31:0] mem_rdata_i;
   logic        div_valid_i;
   logic [4:0]  div_wd_i;
   logic [31:0] div_wdata_i;
   logic        div_ready_o;
   logic        we_o;
   logic [4:0]  waddr_o;
   logic [31:0] wdata_o;
   logic        stallreq_o;

   wb_write_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .mem_wreg_i    (mem_wreg_i),
      .mem_wd_i      (mem_wd_i),
      .mem_wdata_i   (mem_wdata_i),
      .mem_ld_type_i (mem_ld_type_i),
      .mem_addr_lo_i (mem_addr_lo_i),
      .mem_rdata_i   (mem_rdata_i),
      .div_valid_i   (div_valid_i),
      .div_wd_i      (div_wd_i),
      .div_wdata_i   (div_wdata_i),
      .div_ready_o   (div_ready_o),
      .we_o          (we_o),
      .waddr_o       (waddr_o),
      .wdata_o       (wdata_o),
      .stallreq_o    (stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      bit          live;
   } ent_t;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   ent_t mq[$];      // reference late-write queue
   wr_t  expq[$];    // scoreboard of expected register-file writes

   int   n_checks = 0;
   int   n_errors = 0;
   bit   mon_en   = 0;
   bit   mon_rst  = 0;
   bit   exp_ready = 0;
   bit   exp_stall = 0;
   bit   m_ready   = 0;
   int   m_streak  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] f_extract(input logic [2:0] ldt, input logic [1:0] lo,
                                             input logic [31:0] rdata, input logic [31:0] wdata);
      logic [31:0] b;
      logic [31:0] h;
      b = (rdata >> (8 * (3 - int'(lo)))) & 32'hFF;
      h = lo[1] ? (rdata & 32'hFFFF) : (rdata >> 16);
      case (ldt)
         3'd1:    return b[7] ? (b | 32'hFFFF_FF00) : b;
         3'd2:    return b;
         3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
         3'd4:    return h;
         3'd5:    return rdata;
         default: return wdata;
      endcase
   endfunction

   // Reference model for one clock edge, evaluated with the inputs now applied.
   task automatic model_eval();
      bit  slot, accept, has_live, drain, silent;
      int  old_streak;
      wr_t w;
      mon_en = 1;
      if (!rst) begin
         mq.delete();
         mon_rst   = 1;
         m_ready   = 0;
         m_streak  = 0;
         exp_ready = 0;
         exp_stall = 0;
         return;
      end
      mon_rst  = 0;
      slot     = !stall_i && mem_wreg_i && (mem_wd_i != 0);
      accept   = div_valid_i && m_ready;
      has_live = 0;
      foreach (mq[i]) if (mq[i].live) has_live = 1;
      drain  = !slot && mq.size() > 0 && mq[0].live;
      silent = mq.size() > 0 && !mq[0].live;
      if (slot) begin
         w.a = mem_wd_i;
         w.d = f_extract(mem_ld_type_i, mem_addr_lo_i, mem_rdata_i, mem_wdata_i);
         expq.push_back(w);
      end else if (drain) begin
         w.a = mq[0].a;
         w.d = mq[0].d;
         expq.push_back(w);
      end
      old_streak = m_streak;
      if (drain || !has_live) m_streak = 0;
      else if (m_streak < LIMIT) m_streak++;
      exp_stall = !drain && (old_streak == LIMIT);
      if (drain || silent) void'(mq.pop_front());
      if (slot) foreach (mq[i]) if (mq[i].a == mem_wd_i) mq[i].live = 0;
      if (accept && div_wd_i != 0 && !(slot && div_wd_i == mem_wd_i)) begin
         ent_t e;
         e.a = div_wd_i;
         e.d = div_wdata_i;
         e.live = 1;
         mq.push_back(e);
      end
      m_ready   = (mq.size() < DEPTH);
      exp_ready = m_ready;
   endtask

   // Monitor: compares every presented write against the scoreboard head.
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (mon_rst) begin
            chk("reset_outputs", {23'd0, we_o, waddr_o, wdata_o, stallreq_o, div_ready_o}, 64'd0);
         end else begin
            chk("div_ready", div_ready_o, exp_ready);
            chk("stallreq", stallreq_o, exp_stall);
            if (we_o) begin
               if (expq.size() == 0) begin
                  chk("spurious_write", {waddr_o, wdata_o}, 64'd0);
               end else begin
                  wr_t e;
                  e = expq.pop_front();
                  chk("write", {waddr_o, wdata_o}, {e.a, e.d});
               end
            end
            chk("write_pending", expq.size(), 0);
            expq.delete();
         end
      end
   end

   task automatic step();
      model_eval();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      stall_i = 0; mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
      mem_ld_type_i = 0; mem_addr_lo_i = 0; mem_rdata_i = 0;
      div_valid_i = 0; div_wd_i = 0; div_wdata_i = 0;
   endtask

   task automatic pipe(input logic [4:0] wd, input logic [31:0] d);
      mem_wreg_i = 1; mem_wd_i = wd; mem_wdata_i = d; mem_ld_type_i = 0;
   endtask

   task automatic load(input logic [2:0] ldt, input logic [1:0] lo, input logic [31:0] rd);
      mem_wreg_i = 1; mem_wd_i = 5'd2; mem_ld_type_i = ldt; mem_addr_lo_i = lo; mem_rdata_i = rd;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 0;
      idle();
      // 1: reset, then a plain ALU write
      pipe(5'd3, 32'h1234_5678);
      repeat (3) step();
      rst = 1;
      step();
      chk("t1_write", {we_o, waddr_o, wdata_o}, {1'b1, 5'd3, 32'h1234_5678});
      // 2: big-endian load extraction
      load(3'd1, 2'd0, 32'h80FF_7F01); step(); chk("t2_lb",  wdata_o, 32'hFFFF_FF80);
      load(3'd2, 2'd1, 32'h80FF_7F01); step(); chk("t2_lbu", wdata_o, 32'h0000_00FF);
      load(3'd3, 2'd2, 32'h80FF_7F01); step(); chk("t2_lh",  wdata_o, 32'h0000_7F01);
      load(3'd4, 2'd0, 32'h80FF_7F01); step(); chk("t2_lhu", wdata_o, 32'h0000_80FF);
      // 3: starvation, then drain on a stalled slot
      idle(); pipe(5'd7, 32'h77);
      div_valid_i = 1; div_wd_i = 5'd5; div_wdata_i = 32'hA;
      step();
      div_valid_i = 0;
      repeat (4) step();
      chk("t3_stall_low", stallreq_o, 1'b0);
      step();
      chk("t3_stall_high", stallreq_o, 1'b1);
      stall_i = 1;
      step();
      chk("t3_drain", {we_o, waddr_o, wdata_o, stallreq_o}, {1'b1, 5'd5, 32'hA, 1'b0});
      // 4: fill queue, hold a third result, drain in order on $0 writes
      idle(); pipe(5'd7, 32'h77);
      div_valid_i = 1; div_wd_i = 5'd4; div_wdata_i = 32'h44; step();
      div_wd_i = 5'd6; div_wdata_i = 32'h66; step();
      div_wd_i = 5'd8; div_wdata_i = 32'h88; step();
      chk("t4_full", div_ready_o, 1'b0);
      mem_wd_i = 5'd0;
      step(); chk("t4_first",  {we_o, waddr_o, wdata_o}, {1'b1, 5'd4, 32'h44});
      step(); chk("t4_second", {we_o, waddr_o, wdata_o, div_ready_o}, {1'b1, 5'd6, 32'h66, 1'b1});
      idle();
      repeat (3) step();
      // 5: younger pipeline write supersedes a queued divider result
      pipe(5'd7, 32'h77);
      div_valid_i = 1; div_wd_i = 5'd9; div_wdata_i = 32'h1; step();
      idle(); pipe(5'd9, 32'h2); step();
      chk("t5_pipe", {we_o, waddr_o, wdata_o}, {1'b1, 5'd9, 32'h2});
      idle(); step();
      chk("t5_silent", we_o, 1'b0);
      repeat (2) step();
      // 6: reset with two entries queued discards them
      pipe(5'd7, 32'h77);
      div_valid_i = 1; div_wd_i = 5'd10; div_wdata_i = 32'hB0; step();
      div_wd_i = 5'd11; div_wdata_i = 32'hB1; step();
      idle(); rst = 0; step();
      rst = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_no_write", we_o, 1'b0);
      end
      // Randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 299) != 0);
         stall_i       = ($urandom_range(0, 3) == 0);
         mem_wreg_i    = ($urandom_range(0, 3) != 0);
         mem_wd_i      = 5'($urandom_range(0, 7));
         mem_wdata_i   = $urandom;
         mem_ld_type_i = 3'($urandom_range(0, 5));
         mem_addr_lo_i = 2'($urandom_range(0, 3));
         mem_rdata_i   = $urandom;
         div_valid_i   = ($urandom_range(0, 2) == 0);
         div_wd_i      = 5'($urandom_range(0, 7));
         div_wdata_i   = $urandom;
         step();
      end
      idle();
      repeat (6) step();
      chk("final_queue", expq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
